// File: rtl/serial_slice_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_slice_adder_pkg
//  Description : Shared definitions for the serial slice adder: FSM state
//                encodings and the default datapath word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_slice_adder_pkg;

    // Default MIPS datapath word width
    localparam int WORD_WIDTH = 32;

    // Sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : serial_slice_adder_pkg
`default_nettype wire

// File: rtl/serial_slice_adder_twobit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : twobit_adder
//  Description : Combinational 2-bit full adder slice with carry in/out.
//  Revision    : 1.0 - initial release
// ============================================================================
module twobit_adder (
    input  logic [1:0] in_1,
    input  logic [1:0] in_2,
    input  logic       c_in,
    output logic [1:0] out,
    output logic       c_out
);

    // 3-bit result keeps the carry out of the slice
    assign {c_out, out} = {1'b0, in_1} + {1'b0, in_2} + {2'b00, c_in};

endmodule : twobit_adder
`default_nettype wire

// File: rtl/serial_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_slice_adder
//  Description : Multi-cycle WIDTH-bit adder computing in_a + in_b + c_in by
//                reusing one 2-bit adder slice for WIDTH/2 clock cycles.
//                Operands are shifted out LSB-first; the partial sum is
//                shifted in from the top so that the first slice ends up in
//                the LSBs after the final step.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_slice_adder
    import serial_slice_adder_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    // Counter value on the final slice step
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH / 2 - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic             r_sa;
    logic             r_sb;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_new_psum;
    logic             w_last;

    // The single shared slice, fed from the operand LSBs and running carry
    twobit_adder u_slice (
        .in_1  (r_a[1:0]),
        .in_2  (r_b[1:0]),
        .c_in  (r_carry),
        .out   (w_slice_sum),
        .c_out (w_slice_cout)
    );

    // Partial sum after this step: slice output enters at the top
    assign w_new_psum = {w_slice_sum, r_psum[WIDTH-1:2]};
    assign w_last     = (r_cnt == C_LAST_CNT);

    // Sequencer and datapath: capture on start, one slice per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_psum   <= '0;
            r_carry  <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= c_in;
                        r_sa    <= in_a[WIDTH-1];
                        r_sb    <= in_b[WIDTH-1];
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= {2'b00, r_a[WIDTH-1:2]};
                    r_b     <= {2'b00, r_b[WIDTH-1:2]};
                    r_psum  <= w_new_psum;
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        sum      <= w_new_psum;
                        c_out    <= w_slice_cout;
                        overflow <= (r_sa == r_sb) && (w_new_psum[WIDTH-1] != r_sa);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_slice_adder
`default_nettype wire

// File: tb/tb_serial_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_slice_adder
//  Description : Scoreboard testbench for serial_slice_adder (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_slice_adder;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    serial_slice_adder #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_a     (in_a),
        .in_b     (in_b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done with sum %0h, expected no done", sum);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", sum, e.s);
                check("c_out", {31'd0, c_out}, {31'd0, e.c});
                check("overflow", {31'd0, overflow}, {31'd0, e.o});
            end
        end
    end

    // Present a start for one edge; optionally record the expected result
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                         input bit push, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        c_in  = ci;
        if (push) begin
            e.s = es;
            e.c = ec;
            e.o = eo;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done; returns negedges until done, busy cycles and sum seen mid-run
    task automatic wait_done(input bit scramble, input bit pulse, output int lat,
                             output int busy_cnt, output logic [WIDTH-1:0] mid_sum);
        lat      = 0;
        busy_cnt = 0;
        mid_sum  = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i == 8) mid_sum = sum;
            if (scramble) begin
                in_a = $urandom;
                in_b = $urandom;
                c_in = 1'($urandom_range(0, 1));
            end
            if (pulse && i == 5) begin
                start = 1'b1;
                in_a  = 32'hDEAD_BEEF;
                in_b  = 32'h0000_0001;
            end
            if (pulse && i == 6) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done in 40 cycles, expected done");
        end
    endtask

    initial begin
        int lat, bcnt;
        logic [WIDTH-1:0] mid;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        c_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout_ovf", {30'd0, c_out, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-run: abandoned operation produces no done
        issue(32'h0000_00FF, 32'h1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sum", sum, 32'd0);
        check("midrst_cout", {31'd0, c_out}, 32'd0);

        // Basic add with latency and busy-length checks
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, lat, bcnt, mid);
        check("basic_latency", lat, 32'd17);
        check("basic_busy_cycles", bcnt, 32'd16);
        check("basic_sum_hold", mid, 32'd0);
        check("done_one_cycle_pre", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Wrap-around
        issue(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_done(1'b0, 1'b0, lat, bcnt, mid);
        @(negedge clk);

        // Signed overflow, positive and negative
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        wait_done(1'b0, 1'b0, lat, bcnt, mid);
        @(negedge clk);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        wait_done(1'b0, 1'b0, lat, bcnt, mid);
        @(negedge clk);

        // Back-to-back start in the done cycle, plus an ignored mid-run start
        issue(32'h0000_000A, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_000F, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0, lat, bcnt, mid);
        issue(32'h3, 32'h2, 1'b0, 1'b1, 32'h5, 1'b0, 1'b0);
        wait_done(1'b0, 1'b1, lat, bcnt, mid);
        check("b2b_latency", lat, 32'd17);
        check("b2b_sum_hold", mid, 32'h0000_000F);
        repeat (20) @(negedge clk);
        check("ignored_start_busy", {31'd0, busy}, 32'd0);

        // Operands scrambled after capture
        issue(32'h0F0F_0F0F, 32'h1010_1010, 1'b1, 1'b1, 32'h1F1F_1F20, 1'b0, 1'b0);
        wait_done(1'b1, 1'b0, lat, bcnt, mid);
        start = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_slice_adder
`default_nettype wire
